// File: rtl/w_serializer.sv
// Parallel-to-serial pattern source for the lab06 sequence detector's w input.
// Optional cyclic replay of the loaded pattern is enabled by defining W_SERIALIZER_REPEAT_EN.
module w_serializer #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 1,
  localparam int CW      = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
`ifdef W_SERIALIZER_REPEAT_EN
  input  logic             Repeat,
`endif
  output logic             w,
  output logic             Valid,
  output logic             Strobe,
  output logic             Busy,
  output logic             Done,
  output logic [CW-1:0]    BitCount
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [TW-1:0]    tick_q,   tick_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             last_tick;
  logic             last_bit;

`ifdef W_SERIALIZER_REPEAT_EN
  logic [WIDTH-1:0] copy_q, copy_d;
`endif

  assign last_tick = (tick_q == TW'(TICK_DIV - 1));
  assign last_bit  = (bitcnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    tick_d   = tick_q;
    bitcnt_d = bitcnt_q;
`ifdef W_SERIALIZER_REPEAT_EN
    copy_d   = copy_q;
`endif
    case (state_q)
      IDLE: begin
        if (Load) begin
          shreg_d  = Data;
          tick_d   = '0;
          bitcnt_d = '0;
          state_d  = SHIFT;
`ifdef W_SERIALIZER_REPEAT_EN
          copy_d   = Data;
`endif
        end
      end
      SHIFT: begin
        if (!last_tick) begin
          tick_d = tick_q + TW'(1);
        end else begin
          // Normal shift also leaves bitcnt at WIDTH, which is what DONE reports.
          shreg_d  = shreg_q << 1;
          tick_d   = '0;
          bitcnt_d = bitcnt_q + CW'(1);
          if (last_bit) begin
            state_d = DONE;
`ifdef W_SERIALIZER_REPEAT_EN
            if (Repeat) begin
              shreg_d  = copy_q;
              bitcnt_d = '0;
              state_d  = SHIFT;
            end
`endif
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        bitcnt_d = '0;
      end
      default: begin
        state_d  = IDLE;
        tick_d   = '0;
        bitcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      tick_q   <= '0;
      bitcnt_q <= '0;
`ifdef W_SERIALIZER_REPEAT_EN
      copy_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
`ifdef W_SERIALIZER_REPEAT_EN
      copy_q   <= copy_d;
`endif
    end
  end

  assign Valid    = (state_q == SHIFT);
  assign Busy     = (state_q == SHIFT);
  assign w        = Valid & shreg_q[WIDTH-1];
  assign Strobe   = Valid & last_tick;
  assign Done     = (state_q == DONE);
  assign BitCount = (state_q == SHIFT || state_q == DONE) ? bitcnt_q : '0;

endmodule

// File: tb/tb_w_serializer.sv
// Directed scoreboard bench for w_serializer: two instances, TICK_DIV=1 and TICK_DIV=3.
module tb_w_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn_a, ld_a, w_a, v_a, s_a, b_a, dn_a;
  logic [7:0] d_a;
  logic [3:0] bc_a;
  logic       rn_b, ld_b, w_b, v_b, s_b, b_b, dn_b;
  logic [7:0] d_b;
  logic [3:0] bc_b;
  logic       rep;

  w_serializer #(.WIDTH(8), .TICK_DIV(1)) u_a (
    .Clock(clk), .Resetn(rn_a), .Load(ld_a), .Data(d_a),
`ifdef W_SERIALIZER_REPEAT_EN
    .Repeat(rep),
`endif
    .w(w_a), .Valid(v_a), .Strobe(s_a), .Busy(b_a), .Done(dn_a), .BitCount(bc_a));

  w_serializer #(.WIDTH(8), .TICK_DIV(3)) u_b (
    .Clock(clk), .Resetn(rn_b), .Load(ld_b), .Data(d_b),
`ifdef W_SERIALIZER_REPEAT_EN
    .Repeat(rep),
`endif
    .w(w_b), .Valid(v_b), .Strobe(s_b), .Busy(b_b), .Done(dn_b), .BitCount(bc_b));

  typedef struct {
    logic       w;
    logic       v;
    logic       s;
    logic       bsy;
    logic       dn;
    logic [3:0] bc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int strobes, busys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observe(input int which);
    exp_t o;
    if (which == 0) begin
      o.w = w_a; o.v = v_a; o.s = s_a; o.bsy = b_a; o.dn = dn_a; o.bc = bc_a;
    end else begin
      o.w = w_b; o.v = v_b; o.s = s_b; o.bsy = b_b; o.dn = dn_b; o.bc = bc_b;
    end
    return o;
  endfunction

  task automatic cmp(input int which, input string tag, input exp_t e);
    exp_t o;
    o = observe(which);
    chk({tag, ".w"},        32'(o.w),   32'(e.w));
    chk({tag, ".Valid"},    32'(o.v),   32'(e.v));
    chk({tag, ".Strobe"},   32'(o.s),   32'(e.s));
    chk({tag, ".Busy"},     32'(o.bsy), 32'(e.bsy));
    chk({tag, ".Done"},     32'(o.dn),  32'(e.dn));
    chk({tag, ".BitCount"}, 32'(o.bc),  32'(e.bc));
  endtask

  // Expected per-cycle outputs from the first SHIFT cycle through DONE and one IDLE cycle.
  task automatic push_pattern(input logic [7:0] d, input int td);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      for (int t = 0; t < td; t++) begin
        e.w = d[i]; e.v = 1'b1; e.s = (t == td - 1); e.bsy = 1'b1; e.dn = 1'b0;
        e.bc = 4'(7 - i);
        q.push_back(e);
      end
    end
    e.w = 1'b0; e.v = 1'b0; e.s = 1'b0; e.bsy = 1'b0; e.dn = 1'b1; e.bc = 4'd8;
    q.push_back(e);
    e.dn = 1'b0; e.bc = 4'd0;
    q.push_back(e);
  endtask

  // Pops and compares up to nmax entries; inj >= 0 raises a Load with Data=0 during that cycle.
  task automatic drain(input int which, input string tag, input int inj, input int nmax);
    exp_t e;
    int n;
    n = 0;
    strobes = 0;
    busys = 0;
    while (q.size() > 0 && n < nmax) begin
      @(negedge clk);
      if (which == 0) begin
        ld_a = (n == inj);
        if (n == inj) d_a = 8'h00;
      end else begin
        ld_b = (n == inj);
        if (n == inj) d_b = 8'h00;
      end
      e = q.pop_front();
      cmp(which, $sformatf("%s[%0d]", tag, n), e);
      if (observe(which).s) strobes++;
      if (observe(which).bsy) busys++;
      n++;
    end
    ld_a = 1'b0;
    ld_b = 1'b0;
  endtask

  exp_t zero;

  initial begin
    zero.w = 0; zero.v = 0; zero.s = 0; zero.bsy = 0; zero.dn = 0; zero.bc = 0;
    rep = 1'b0;
    rn_a = 1'b0; ld_a = 1'b1; d_a = 8'hFF;
    rn_b = 1'b0; ld_b = 1'b0; d_b = 8'h00;
    repeat (2) @(negedge clk);
    cmp(0, "reset_a", zero);
    cmp(1, "reset_b", zero);
    ld_a = 1'b0;
    rn_a = 1'b1; rn_b = 1'b1;
    @(negedge clk);
    cmp(0, "idle_a", zero);

    // Reset and Load at the same edge: must stay idle.
    rn_a = 1'b0; ld_a = 1'b1; d_a = 8'hAA;
    @(negedge clk);
    rn_a = 1'b1; ld_a = 1'b0;
    cmp(0, "rst_vs_load", zero);
    @(negedge clk);
    cmp(0, "rst_vs_load_after", zero);

    // Basic F0 pattern at one clock per bit.
    ld_a = 1'b1; d_a = 8'hF0;
    push_pattern(8'hF0, 1);
    drain(0, "f0", -1, 100);
    chk("f0.strobes", 32'(strobes), 32'd8);
    chk("f0.busy", 32'(busys), 32'd8);

    // B4 pattern at three clocks per bit.
    ld_b = 1'b1; d_b = 8'hB4;
    push_pattern(8'hB4, 3);
    drain(1, "b4", -1, 100);
    chk("b4.strobes", 32'(strobes), 32'd8);
    chk("b4.busy", 32'(busys), 32'd24);

    // Load with Data=00 during the third SHIFT cycle is ignored.
    ld_a = 1'b1; d_a = 8'hF0;
    push_pattern(8'hF0, 1);
    drain(0, "ign", 2, 100);
    d_a = 8'hF0;

    // Reset during the fifth bit aborts with no Done.
    ld_a = 1'b1; d_a = 8'hF0;
    push_pattern(8'hF0, 1);
    drain(0, "abort", -1, 5);
    rn_a = 1'b0;
    q.delete();
    @(negedge clk);
    rn_a = 1'b1;
    cmp(0, "abort_rst", zero);
    @(negedge clk);
    cmp(0, "abort_idle", zero);

    // Clean restart from the MSB after reset.
    ld_a = 1'b1; d_a = 8'hA5;
    push_pattern(8'hA5, 1);
    drain(0, "restart", -1, 100);

    // Back-to-back loads: the edge ending the IDLE cycle after DONE is accepted.
    ld_a = 1'b1; d_a = 8'h81;
    push_pattern(8'h81, 1);
    drain(0, "b2b1", -1, 9);
    @(negedge clk);
    ld_a = 1'b1; d_a = 8'h3C;
    q.delete();
    cmp(0, "b2b_idle", zero);
    push_pattern(8'h3C, 1);
    drain(0, "b2b2", -1, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
